uart_rx_palabra: RTL and testbench

//  UART 8N1 receiver that reassembles serial bytes into 32-bit words. It is
//  the receive-side counterpart of the TX chain: it consumes the Tx line

---
 rtl/uart_rx_palabra_pkg.sv | 23 ++
 rtl/uart_rx_palabra_generador_tick_rx.sv | 34 +++
 rtl/uart_rx_palabra.sv | 154 +++++++++++++++
 tb/tb_uart_rx_palabra.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_palabra_pkg.sv
// Shared definitions for the UART word receiver.
//   estado_t    : receiver FSM states (3-bit encoding)
//   OVERSAMPLE  : ticks per serial bit
//   calc_div    : rounded clock divider for the x16 baud tick
package uart_rx_palabra_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    ESPERA = 3'd4
  } estado_t;

  // round(clk_freq / (OVERSAMPLE * baud))
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_palabra_generador_tick_rx.sv
// Free-running baud x16 tick generator.
//   clk   : system clock
//   reset : asynchronous reset, active high
//   tick  : one-cycle pulse every DIV clocks
module generador_tick_rx
  import uart_rx_palabra_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_palabra.sv
// UART 8N1 receiver that reassembles BYTES serial bytes into one word.
//   clk         : system clock
//   reset       : asynchronous reset, active high
//   Rx          : serial input, idle high, asynchronous
//   dato        : last complete word, first byte received in bits [7:0]
//   listo       : one-cycle strobe, dato updated
//   error_trama : one-cycle strobe, stop bit sampled low
//   ocupado     : high whenever the FSM is not in IDLE
module uart_rx_palabra
  import uart_rx_palabra_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned BYTES      = 4,
  parameter int unsigned TIMEOUT_BT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic [8*BYTES-1:0]   dato,
  output logic                 listo,
  output logic                 error_trama,
  output logic                 ocupado
);

  localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TO_LIM = TIMEOUT_BT * 10 * OVERSAMPLE;
  localparam int unsigned TO_W   = $clog2(TO_LIM + 1);

  logic               rx_m, rx_s;
  logic               tick;
  estado_t            estado, estado_n;
  logic [3:0]         tick_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         sh;
  logic [8*BYTES-1:0] word, word_n;
  logic [IDX_W-1:0]   idx;
  logic [TO_W-1:0]    to_cnt;

  logic mid, fin, arrancar, muestra_bit, byte_ok, fallo, to_fire;

  generador_tick_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_n;
  end

  assign mid = tick && (tick_cnt == 4'd7);
  assign fin = tick && (tick_cnt == 4'd15);

  always_comb begin
    estado_n    = estado;
    arrancar    = 1'b0;
    muestra_bit = 1'b0;
    byte_ok     = 1'b0;
    fallo       = 1'b0;
    case (estado)
      IDLE:   if (!rx_s) begin
                estado_n = START;
                arrancar = 1'b1;
              end
      START:  if (mid) estado_n = rx_s ? IDLE : DATA;
      DATA:   if (fin) begin
                muestra_bit = 1'b1;
                if (bit_cnt == 3'd7) estado_n = STOP;
              end
      STOP:   if (fin) begin
                if (rx_s) begin
                  byte_ok  = 1'b1;
                  estado_n = IDLE;
                end else begin
                  fallo    = 1'b1;
                  estado_n = ESPERA;
                end
              end
      // Wait for the line to return high so a held break cannot retrigger.
      ESPERA: if (rx_s) estado_n = IDLE;
      default: estado_n = IDLE;
    endcase
  end

  // Word with the just-completed byte merged in; dato must see it in the same cycle.
  always_comb begin
    word_n = word;
    word_n[{idx, 3'b000} +: 8] = sh;
  end

  assign to_fire = (estado == IDLE) && (idx != '0) && tick && (to_cnt == TO_W'(TO_LIM - 1));
  assign ocupado = (estado != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      word        <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      dato        <= '0;
      listo       <= 1'b0;
      error_trama <= 1'b0;
    end else begin
      listo       <= 1'b0;
      error_trama <= 1'b0;

      // Re-phasing at the start-bit centre puts every later sample mid-bit.
      if (arrancar || (estado == START && mid)) tick_cnt <= '0;
      else if (tick)                            tick_cnt <= tick_cnt + 4'd1;

      if (estado == START && mid) bit_cnt <= '0;
      else if (muestra_bit)       bit_cnt <= bit_cnt + 3'd1;

      if (muestra_bit) sh <= {rx_s, sh[7:1]};

      if (byte_ok) begin
        word <= word_n;
        if (idx == IDX_W'(BYTES - 1)) begin
          dato  <= word_n;
          listo <= 1'b1;
          idx   <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (fallo) begin
        error_trama <= 1'b1;
        idx         <= '0;
      end else if (to_fire) begin
        idx <= '0;
      end

      if (arrancar || to_fire)                        to_cnt <= '0;
      else if (estado == IDLE && idx != '0 && tick)   to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_palabra.sv
// Self-checking bench for uart_rx_palabra: a bit-level serial driver plays
// the transmitter, a negedge monitor counts strobes.
module tb_uart_rx_palabra;

  localparam int unsigned CLK_FREQ = 7_372_800;  // DIV = 4 at 115200 baud
  localparam int unsigned BAUD     = 115_200;
  localparam int          BIT      = 64;         // 16 ticks * 4 clk

  logic        clk = 1'b0;
  logic        reset;
  logic        Rx;
  logic [31:0] dato;
  logic        listo, error_trama, ocupado;

  int n_checks = 0;
  int n_fail   = 0;
  int n_listo  = 0;
  int n_err    = 0;
  int n_both   = 0;
  int l0, e0;

  uart_rx_palabra #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .BYTES      (4),
    .TIMEOUT_BT (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rx          (Rx),
    .dato        (dato),
    .listo       (listo),
    .error_trama (error_trama),
    .ocupado     (ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (listo)                n_listo++;
    if (error_trama)          n_err++;
    if (listo && error_trama) n_both++;
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_dato;
    int          exp_listo;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    Rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'h1234_5678, 32'h1234_5678, 1};
    vecs[1] = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
    vecs[4] = '{32'h8000_0001, 32'h8000_0001, 1};

    Rx    = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dato", dato, 32'h0);
    check("reset_listo", {31'b0, listo}, 32'h0);
    check("reset_error", {31'b0, error_trama}, 32'h0);
    check("reset_ocupado", {31'b0, ocupado}, 32'h0);
    reset = 1'b0;
    idle(10);

    // Back-to-back words, first byte to bits [7:0]
    for (int v = 0; v < 5; v++) begin
      l0 = n_listo;
      e0 = n_err;
      send_word(vecs[v].word);
      idle(8);
      check($sformatf("vec%0d_dato", v), dato, vecs[v].exp_dato);
      check($sformatf("vec%0d_listo", v), n_listo - l0, vecs[v].exp_listo);
      check($sformatf("vec%0d_err", v), n_err - e0, 32'd0);
    end

    // Short low glitch between bytes: no strobe, byte index preserved
    l0 = n_listo;
    e0 = n_err;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    Rx = 1'b0;
    repeat (16) @(negedge clk);
    idle(60);
    check("glitch_ocupado", {31'b0, ocupado}, 32'h0);
    check("glitch_nostrobe", (n_listo - l0) + (n_err - e0), 32'd0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(8);
    check("glitch_dato", dato, 32'h4433_2211);
    check("glitch_listo", n_listo - l0, 32'd1);

    // Framing error then held break: parks until the line returns high
    l0 = n_listo;
    e0 = n_err;
    send_byte(8'hAA, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    check("brk_err", n_err - e0, 32'd1);
    check("brk_listo", n_listo - l0, 32'd0);
    check("brk_ocupado", {31'b0, ocupado}, 32'h1);
    idle(10);
    check("brk_release", {31'b0, ocupado}, 32'h0);
    send_word(32'h0403_0201);
    idle(8);
    check("brk_dato", dato, 32'h0403_0201);
    check("brk_listo2", n_listo - l0, 32'd1);
    check("brk_err2", n_err - e0, 32'd1);

    // Two bytes, long idle: partial word must be dropped
    l0 = n_listo;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle(3 * 10 * BIT);
    send_word(32'hEFBE_ADDE);
    idle(8);
    check("to_dato", dato, 32'hEFBE_ADDE);
    check("to_listo", n_listo - l0, 32'd1);

    // Reset during bit 4 of the third byte
    l0 = n_listo;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    Rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dato", dato, 32'h0);
    check("rst_listo", {31'b0, listo}, 32'h0);
    check("rst_error", {31'b0, error_trama}, 32'h0);
    check("rst_ocupado", {31'b0, ocupado}, 32'h0);
    reset = 1'b0;
    idle(10);
    send_word(32'h4433_2211);
    idle(8);
    check("rst_word_dato", dato, 32'h4433_2211);
    check("rst_word_listo", n_listo - l0, 32'd1);

    check("strobes_exclusive", n_both, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
